// File: rtl/matvec_pkg.sv
// Shared constants and types for the matvec result requantizer.
// Holds the element widths, the clip bounds and the per-stage payload layouts.
package matvec_pkg;
    localparam int K       = 8;
    localparam int IN_W    = 28;
    localparam int OUT_W   = 14;
    localparam int IDX_W   = $clog2(K);
    localparam int OUT_MAX = 2**(OUT_W-1) - 1;
    localparam int OUT_MIN = -(2**(OUT_W-1));

    typedef logic [IDX_W-1:0] idx_t;

    // S1 payload: rounded/shifted value, one bit wider than the input
    typedef struct packed {
        logic signed [IN_W:0] r;
        idx_t                 idx;
        logic                 last;
        logic                 relu;
    } s1_t;

    // S2 payload: final element plus its saturation flag
    typedef struct packed {
        logic signed [OUT_W-1:0] data;
        idx_t                    idx;
        logic                    last;
        logic                    sat;
    } s2_t;

    function automatic logic [4:0] clamp_shift(input logic [4:0] s);
        return (int'(s) > IN_W-1) ? 5'(IN_W-1) : s;
    endfunction
endpackage

// File: rtl/rq_pipe_stage.sv
// One pipeline register: valid bit plus payload, moving only when adv is high.
// The payload is loaded only with a valid element so an idle stage keeps its last value.
module rq_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         adv,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            out_valid <= in_valid;
            if (in_valid)
                out_data <= in_data;
        end
    end
endmodule

// File: rtl/matvec_result_requant.sv
// Requantizes the 28-bit matvec result stream to 14 bits: round-shift, clip, optional ReLU.
// Two-stage valid/ready pipeline that tags each element with its row index and end-of-vector.
module matvec_result_requant
    import matvec_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic [4:0]              shift,
    input  logic                    relu_en,
    input  logic                    clear_stats,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output idx_t                    out_index,
    output logic                    out_last,
    output logic [7:0]              sat_count
);
    localparam logic signed [IN_W:0] R_MAX = (IN_W+1)'(OUT_MAX);
    localparam logic signed [IN_W:0] R_MIN = (IN_W+1)'(OUT_MIN);

    logic s1_valid, s2_valid, s1_adv, s2_adv, in_xfer, out_xfer;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    idx_t acc_cnt;
    logic [4:0] shift_q, cur_shift;
    logic relu_q, cur_relu;
    logic signed [IN_W:0] ext, bias, sum, r2;

    // Backpressure ripples combinationally from out_ready back to in_ready
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = s2_valid && out_ready;

    // Element 0 uses the live config; the rest of the vector uses the latched copy
    assign cur_shift = (acc_cnt == '0) ? clamp_shift(shift) : shift_q;
    assign cur_relu  = (acc_cnt == '0) ? relu_en : relu_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_cnt <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
        end else if (in_xfer) begin
            acc_cnt <= (acc_cnt == IDX_W'(K-1)) ? '0 : acc_cnt + 1'b1;
            if (acc_cnt == '0) begin
                shift_q <= cur_shift;
                relu_q  <= cur_relu;
            end
        end
    end

    // Round half toward +inf: add 2^(s-1) then arithmetic shift
    always_comb begin
        ext  = in_data;
        bias = '0;
        if (cur_shift != '0)
            bias = (IN_W+1)'(1) << (cur_shift - 5'd1);
        sum       = ext + bias;
        s1_d.r    = sum >>> cur_shift;
        s1_d.idx  = acc_cnt;
        s1_d.last = (acc_cnt == IDX_W'(K-1));
        s1_d.relu = cur_relu;
    end

    rq_pipe_stage #(.W($bits(s1_t))) u_s1 (
        .clk       (clk),
        .reset     (reset),
        .adv       (s1_adv),
        .in_valid  (in_valid),
        .in_data   (s1_d),
        .out_valid (s1_valid),
        .out_data  (s1_q)
    );

    // Saturation is flagged before ReLU; a ReLU-zeroed element is never counted
    always_comb begin
        r2        = s1_q.r;
        s2_d.idx  = s1_q.idx;
        s2_d.last = s1_q.last;
        s2_d.sat  = 1'b0;
        if (r2 > R_MAX) begin
            s2_d.data = OUT_W'(OUT_MAX);
            s2_d.sat  = 1'b1;
        end else if (r2 < R_MIN) begin
            s2_d.data = OUT_W'(OUT_MIN);
            s2_d.sat  = 1'b1;
        end else begin
            s2_d.data = r2[OUT_W-1:0];
        end
        if (s1_q.relu && s2_d.data[OUT_W-1]) begin
            s2_d.data = '0;
            s2_d.sat  = 1'b0;
        end
    end

    rq_pipe_stage #(.W($bits(s2_t))) u_s2 (
        .clk       (clk),
        .reset     (reset),
        .adv       (s2_adv),
        .in_valid  (s1_valid),
        .in_data   (s2_d),
        .out_valid (s2_valid),
        .out_data  (s2_q)
    );

    always_ff @(posedge clk) begin
        if (reset || clear_stats)
            sat_count <= '0;
        else if (out_xfer && s2_q.sat && sat_count != 8'hFF)
            sat_count <= sat_count + 8'd1;
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_q.data;
    assign out_index = s2_q.idx;
    assign out_last  = s2_q.last;
endmodule

// File: tb/tb_matvec_result_requant.sv
// Directed bench for matvec_result_requant: hand-computed vectors checked with immediate assertions.
// Outputs are captured into a queue on the falling edge and popped in order.
module tb_matvec_result_requant;
    import matvec_pkg::*;

    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, relu_en = 1'b0;
    logic clear_stats = 1'b0, out_ready = 1'b1;
    logic signed [IN_W-1:0] in_data = '0;
    logic [4:0] shift = '0;
    logic in_ready, out_valid, out_last;
    logic signed [OUT_W-1:0] out_data;
    idx_t out_index;
    logic [7:0] sat_count;

    int n_tests = 0, n_fail = 0;
    int k;

    typedef struct {
        logic signed [31:0] d;
        logic signed [31:0] i;
        logic signed [31:0] l;
    } obs_t;
    obs_t q[$];

    logic signed [IN_W-1:0] vin[16];
    int vsh[16];
    int vexp[16];
    logic vrelu;

    always #5 clk = ~clk;

    matvec_result_requant dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .shift       (shift),
        .relu_en     (relu_en),
        .clear_stats (clear_stats),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last),
        .sat_count   (sat_count)
    );

    always @(negedge clk)
        if (!reset && out_valid && out_ready)
            q.push_back('{$signed(out_data), {29'd0, out_index}, {31'd0, out_last}});

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic setv(input int i, input logic signed [IN_W-1:0] d, input int sh, input int e);
        vin[i] = d; vsh[i] = sh; vexp[i] = e;
    endtask

    // Holds the element on the inputs until it is accepted; returns at posedge+1
    task automatic send_one(input logic signed [IN_W-1:0] d, input int sh, input logic r);
        bit done = 1'b0;
        in_valid = 1'b1; in_data = d; shift = 5'(sh); relu_en = r;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic pop_chk(input string tag, input int ed, input int ei, input int el);
        obs_t o;
        for (int c = 0; c < 50 && q.size() == 0; c++) @(negedge clk);
        if (q.size() == 0) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            o = q.pop_front();
            chk({tag, "_data"}, o.d, ed);
            chk({tag, "_idx"}, o.i, ei);
            chk({tag, "_last"}, o.l, el);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input int lo, input int hi, input string tag);
        for (int i = lo; i < hi; i++) send_one(vin[i], vsh[i], vrelu);
        in_valid = 1'b0;
        for (int i = lo; i < hi; i++) pop_chk(tag, vexp[i], i % 8, (i % 8 == 7) ? 1 : 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_sat_count", sat_count, 0);
        @(posedge clk); #1;

        // Rounding, shift 4
        vrelu = 1'b0;
        setv(0, 1000, 4, 63);  setv(1, -1000, 4, -62); setv(2, 8, 4, 1);  setv(3, -9, 4, -1);
        setv(4, -8, 4, 0);     setv(5, 7, 4, 0);       setv(6, 24, 4, 2); setv(7, -24, 4, -1);
        run_vec(0, 8, "round");
        chk("round_sat", sat_count, 0);

        // Saturation and clip boundaries, shift 0
        setv(0, 28'h7FFFFFF, 0, 8191); setv(1, -5, 0, -5); setv(2, 8191, 0, 8191); setv(3, -8192, 0, -8192);
        setv(4, 0, 0, 0);              setv(5, 1, 0, 1);   setv(6, -1, 0, -1);     setv(7, 100, 0, 100);
        run_vec(0, 8, "sat");
        chk("sat_count1", sat_count, 1);

        // ReLU: clipped negatives zeroed and not counted; positive clip still counted
        vrelu = 1'b1;
        setv(0, 28'h8000000, 0, 0); setv(1, -3, 0, 0); setv(2, 7, 0, 7); setv(3, 8191, 0, 8191);
        setv(4, 28'h7FFFFFF, 0, 8191); setv(5, 0, 0, 0); setv(6, -1, 0, 0); setv(7, 5, 0, 5);
        run_vec(0, 8, "relu");
        chk("relu_sat_count", sat_count, 2);

        // Maximum shift; 31 on element 0 clamps to 27
        vrelu = 1'b0;
        setv(0, 28'h7FFFFFF, 31, 1); setv(1, -1, 27, 0); setv(2, 28'h8000000, 27, -1); setv(3, 0, 27, 0);
        setv(4, 1, 27, 0); setv(5, 28'h4000000, 27, 1); setv(6, 28'hC000000, 27, 0); setv(7, 28'h3FFFFFF, 27, 0);
        run_vec(0, 8, "shmax");
        chk("shmax_sat_count", sat_count, 2);

        // Config latch and framing: 16 back-to-back, shift change mid-vector ignored
        for (int i = 0; i < 3; i++) setv(i, 100, 2, 25);
        for (int i = 3; i < 8; i++) setv(i, 100, 6, 25);
        for (int i = 8; i < 16; i++) setv(i, 100, 6, 2);
        setv(9, 200, 6, 3); setv(10, -100, 6, -2); setv(12, 200, 2, 3);
        run_vec(0, 16, "latch");

        // Backpressure: only two elements enter while out_ready is low
        for (int i = 0; i < 8; i++) setv(i, 10 * i + 5, 0, 10 * i + 5);
        out_ready = 1'b0; k = 0;
        in_valid = 1'b1; in_data = vin[0]; shift = '0; relu_en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (in_ready) k++;
            @(posedge clk); #1;
            in_data = vin[k];
        end
        @(negedge clk);
        chk("bp_accepted", k, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_hold_data", out_data, 5);
        @(negedge clk);
        chk("bp_hold_data2", out_data, 5);
        chk("bp_hold_idx", out_index, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 2; i < 8; i++) send_one(vin[i], 0, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) pop_chk("bp", vexp[i], i, (i == 7) ? 1 : 0);
        chk("bp_no_dup", q.size(), 0);

        // Latency: accepted at edge n, visible during the cycle after edge n+1
        send_one(5, 0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_s1_only", out_valid, 0);
        @(negedge clk);
        chk("lat_out_valid", out_valid, 1);
        pop_chk("lat", 5, 0, 0);

        // Reset after 3 of 8 inputs discards the in-flight elements
        send_one(6, 0, 1'b0);
        send_one(7, 0, 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_in_ready", in_ready, 1);
        chk("rst2_no_output", q.size(), 0);
        chk("rst2_sat_count", sat_count, 0);
        @(posedge clk); #1;
        setv(0, 9, 1, 5);
        for (int i = 1; i < 8; i++) setv(i, 0, 4, 0);
        run_vec(0, 8, "rst2");

        // clear_stats wins over a saturating transfer in the same cycle
        out_ready = 1'b0;
        send_one(28'h7FFFFFF, 0, 1'b0);
        in_valid = 1'b0;
        for (int c = 0; c < 20 && !out_valid; c++) begin @(posedge clk); #1; end
        chk("clr_wait_valid", out_valid, 1);
        out_ready = 1'b1; clear_stats = 1'b1;
        @(posedge clk); #1;
        clear_stats = 1'b0;
        @(negedge clk);
        chk("clr_sat_count", sat_count, 0);
        pop_chk("clr", 8191, 0, 0);
        setv(1, 28'h8000000, 0, -8192);
        for (int i = 2; i < 8; i++) setv(i, 3, 0, 3);
        run_vec(1, 8, "clr");
        chk("clr_recount", sat_count, 1);

        // sat_count holds at 255
        for (int i = 0; i < 260; i++) send_one(28'h7FFFFFF, 0, 1'b0);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 q.delete();
        chk("sat_hold_255", sat_count, 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/matvec_result_requant.md
# matvec_result_requant

Downstream stage of the 8×8 matrix-vector multiplier. It consumes the 28-bit signed result stream and converts each element to a 14-bit signed value using rounded arithmetic right shift, saturation and optional ReLU. It tags each element with its row index and an end-of-vector marker, and keeps a saturation statistic. The 14-bit output matches the multiplier's input width, so results can be fed into a following layer.

## Interface
- K, 8, elements per result vector (row count)
- IN_W, 28, input data width (signed)
- OUT_W, 14, output data width (signed)
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  upstream result valid
- in_ready  output  1  stage accepts an element this cycle
- in_data  input  IN_W  signed matvec result
- shift  input  5  right-shift amount; values above IN_W-1 are clamped to IN_W-1
- relu_en  input  1  zero negative results
- clear_stats  input  1  synchronous clear of sat_count
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts
- out_data  output  OUT_W  requantized element
- out_index  output  $clog2(K)  row index of out_data, 0..K-1
- out_last  output  1  high with index K-1
- sat_count  output  8  saturating count of clipped elements

## Operation
- Transfer occurs on a side when valid && ready are both high in the same cycle.
- Accept counter: counts input transfers 0..K-1, then wraps to 0. Its value travels with the element as out_index.
- Config latch: shift and relu_en are sampled on the transfer of element index 0. The sampled values apply to all K elements of that vector. Changes mid-vector are ignored until the next index-0 transfer.
- Stage 1 (round/shift), computed in IN_W+1 bits to avoid overflow:
  - s = 0: r = in_data.
  - s > 0: r = (in_data + 2^(s-1)) >>> s, i.e. round half toward +inf.
- Stage 2 (saturate/ReLU):
  - Clip r to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-8192, 8191].
  - The saturation flag is computed before ReLU.
  - If relu_en is set and the clipped value is negative, output 0. An element zeroed this way does not count as saturated, even if it was also clipped.
- sat_count: increments by 1 when a flagged element transfers out, and holds at 255. clear_stats has priority over an increment in the same cycle.

## Timing
- Two-register pipeline (S1, S2), each with its own valid bit. Throughput 1 element/cycle.
- Latency: input transfer in cycle n gives out_valid in cycle n+2 when there is no backpressure.
- Stall rules:
  - S2 advances when !S2.valid || out_ready.
  - S1 advances when !S1.valid || S2 advances.
  - in_ready = S1 advances. This is a combinational path from out_ready; no skid buffer.
- When out_valid is high and out_ready is low, out_data, out_index and out_last hold stable.
- Full condition: S1 and S2 both valid and out_ready low, so in_ready is low. At most 2 elements are in flight.
- Empty condition: in_ready is high and out_valid is low.
- Simultaneous clear_stats and a counted transfer: result is 0.
- Reset values: out_valid 0, out_data 0, out_index 0, out_last 0, sat_count 0, accept counter 0, S1/S2 valid 0. in_ready is 1 in the first cycle after reset.
- Reset mid-vector discards in-flight elements. The next accepted element is index 0 and latches new config.

## Structure
- Shared package matvec_pkg holds:
  - K, IN_W, OUT_W
  - OUT_MAX / OUT_MIN constants
  - the index typedef logic [$clog2(K)-1:0]
- One sub-module, rq_pipe_stage: a valid/data register with an advance enable, instantiated twice. The datapath logic lives in the top module.

## Test plan
- Rounding: shift=4, relu=0; input 1000 then -1000 → 63, -62. Input 8 → 1; input -9 → -1 (-9+8 = -1, -1>>>4 = -1).
- Saturation/ReLU: shift=0 and relu=0, input 28'h7FFFFFF → 8191, sat_count=1. Next vector with shift=0 and relu=1, input 28'h8000000 → 0, sat_count still 1. Input 28'h7FFFFFF with shift=27 → 1, no saturation.
- Framing: 16 back-to-back inputs → out_index 0..7,0..7; out_last only on the 8th and 16th outputs.
- Config latch: vector starts with shift=2; shift changed to 6 at index 3 → all 8 outputs use shift 2; the next vector uses 6.
- Backpressure: out_ready low for 5 cycles while inputs are offered → exactly 2 accepted and in_ready low. After release, all elements come out in order with no loss or duplication.
- Reset/stats: assert reset after 3 of 8 inputs → outputs stop and the next input emerges with index 0. clear_stats asserted together with a saturating transfer → sat_count 0.
